// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared types, opcodes and opcode classification for the multi-cycle controller
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JALR   = 2'd2
    } pcsrc_t;

    typedef enum logic [3:0] {
        CL_R, CL_IARITH, CL_LOAD, CL_STORE, CL_BRANCH,
        CL_JAL, CL_JALR, CL_LUI, CL_AUIPC, CL_MULDIV, CL_ILLEGAL
    } opclass_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // The mul/div encoding shares the R-type opcode and is only legal with the M extension.
    function automatic opclass_t classify(input logic [6:0] op, input logic [6:0] funct7,
                                          input logic m_ext);
        opclass_t cls;
        case (op)
            OP_R:      cls = (funct7 == F7_MULDIV) ? (m_ext ? CL_MULDIV : CL_ILLEGAL) : CL_R;
            OP_LOAD:   cls = CL_LOAD;
            OP_STORE:  cls = CL_STORE;
            OP_IARITH: cls = CL_IARITH;
            OP_BRANCH: cls = CL_BRANCH;
            OP_JAL:    cls = CL_JAL;
            OP_JALR:   cls = CL_JALR;
            OP_AUIPC:  cls = CL_AUIPC;
            OP_LUI:    cls = CL_LUI;
            default:   cls = CL_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// rtl/mc_alu_decode.sv - maps opcode class and function fields to the ALU control encoding
module mc_alu_decode
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] opclass,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output logic [2:0] alucontrol,
    output logic       alu_sub
);

    always_comb begin
        alucontrol = 3'b000;
        alu_sub    = 1'b0;
        case (opclass)
            CL_R: begin
                alucontrol = funct3;
                alu_sub    = funct7_b5;
            end
            // Immediate forms carry no funct7, so bit 5 only selects srai over srli.
            CL_IARITH: begin
                alucontrol = funct3;
                alu_sub    = (funct3 == 3'b101) && funct7_b5;
            end
            CL_BRANCH: alu_sub = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RV32I control FSM with memory timeouts and sticky traps
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter bit M_EXT        = 1'b0,
    parameter int WAIT_TIMEOUT = 16,
    parameter int INSTRET_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 br_taken,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    input  logic                 muldiv_done,
    output logic                 imem_req,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic [1:0]           pcsrc,
    output logic                 regwrite,
    output logic                 alusrc,
    output logic                 memtoreg,
    output logic                 auipc,
    output logic                 lui,
    output logic                 muldiv_sel,
    output logic [2:0]           alucontrol,
    output logic                 alu_sub,
    output logic                 muldiv_start,
    output logic                 illegal,
    output logic                 bus_err,
    output logic [INSTRET_W-1:0] instret,
    output logic [2:0]           state
);

    localparam bit TIMEOUT_EN = (WAIT_TIMEOUT > 0);
    localparam int WCNT_W     = TIMEOUT_EN ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = TIMEOUT_EN ? WCNT_W'(WAIT_TIMEOUT - 1) : '0;

    state_t            cur, nxt;
    opclass_t          cls;
    logic [WCNT_W-1:0] wait_cnt;
    logic              exec_busy;
    logic              set_illegal, set_bus_err, wait_limit;
    logic [2:0]        alu_ctl;
    logic              alu_sb;

    assign cls        = classify(op, funct7, M_EXT);
    assign wait_limit = TIMEOUT_EN && (wait_cnt == WAIT_LAST);
    assign state      = cur;

    mc_alu_decode u_alu_decode (
        .opclass    (cls),
        .funct3     (funct3),
        .funct7_b5  (funct7[5]),
        .alucontrol (alu_ctl),
        .alu_sub    (alu_sb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= ST_IDLE;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt          = cur;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pcsrc        = PC_PLUS4;
        regwrite     = 1'b0;
        alusrc       = 1'b0;
        memtoreg     = 1'b0;
        auipc        = 1'b0;
        lui          = 1'b0;
        muldiv_sel   = 1'b0;
        alucontrol   = 3'b000;
        alu_sub      = 1'b0;
        muldiv_start = 1'b0;
        set_illegal  = 1'b0;
        set_bus_err  = 1'b0;
        case (cur)
            ST_IDLE: nxt = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we = 1'b1;
                    nxt   = ST_DECODE;
                end else if (wait_limit) begin
                    nxt         = ST_TRAP;
                    set_bus_err = 1'b1;
                end
            end
            ST_DECODE: begin
                if (cls == CL_ILLEGAL) begin
                    nxt         = ST_TRAP;
                    set_illegal = 1'b1;
                end else begin
                    nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alucontrol = alu_ctl;
                alu_sub    = alu_sb;
                alusrc     = (cls == CL_LOAD) || (cls == CL_STORE) || (cls == CL_IARITH);
                lui        = (cls == CL_LUI);
                auipc      = (cls == CL_AUIPC);
                case (cls)
                    CL_BRANCH: begin
                        pc_we = 1'b1;
                        pcsrc = br_taken ? PC_BRANCH : PC_PLUS4;
                        nxt   = ST_FETCH;
                    end
                    CL_LOAD, CL_STORE: nxt = ST_MEM;
                    CL_MULDIV: begin
                        muldiv_start = !exec_busy;
                        if (muldiv_done) nxt = ST_WB;
                    end
                    default: nxt = ST_WB;
                endcase
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls == CL_STORE);
                if (dmem_ready) begin
                    if (cls == CL_STORE) begin
                        pc_we = 1'b1;
                        nxt   = ST_FETCH;
                    end else begin
                        nxt = ST_WB;
                    end
                end else if (wait_limit) begin
                    nxt         = ST_TRAP;
                    set_bus_err = 1'b1;
                end
            end
            ST_WB: begin
                regwrite   = 1'b1;
                pc_we      = 1'b1;
                memtoreg   = (cls == CL_LOAD);
                muldiv_sel = (cls == CL_MULDIV);
                if (cls == CL_JAL)       pcsrc = PC_BRANCH;
                else if (cls == CL_JALR) pcsrc = PC_JALR;
                nxt = ST_FETCH;
            end
            ST_TRAP: nxt = ST_TRAP;
            default: nxt = ST_IDLE;
        endcase
    end

    // The wait counter restarts whenever a FETCH or MEM wait is entered afresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            exec_busy <= 1'b0;
            illegal   <= 1'b0;
            bus_err   <= 1'b0;
            instret   <= '0;
        end else begin
            wait_cnt  <= ((cur == ST_FETCH || cur == ST_MEM) && nxt == cur) ?
                         wait_cnt + WCNT_W'(1) : '0;
            exec_busy <= (cur == ST_EXEC) && (nxt == ST_EXEC);
            if (set_illegal) illegal <= 1'b1;
            if (set_bus_err) bus_err <= 1'b1;
            if (pc_we)       instret <= instret + INSTRET_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized scoreboard bench for the multi-cycle controller
module tb_multicycle_controller;

    localparam int N_INSTR = 200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [6:0]  op, funct7;
    logic [2:0]  funct3;
    logic        br_taken, imem_ready, dmem_ready, muldiv_done;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we;
    logic [1:0]  pcsrc;
    logic        regwrite, alusrc, memtoreg, auipc, lui, muldiv_sel;
    logic [2:0]  alucontrol;
    logic        alu_sub, muldiv_start, illegal, bus_err;
    logic [31:0] instret;
    logic [2:0]  state;

    logic        d0_imem_req, d0_dmem_req, d0_dmem_we, d0_ir_we, d0_pc_we;
    logic [1:0]  d0_pcsrc;
    logic        d0_regwrite, d0_alusrc, d0_memtoreg, d0_auipc, d0_lui, d0_muldiv_sel;
    logic [2:0]  d0_alucontrol;
    logic        d0_alu_sub, d0_muldiv_start, d0_illegal, d0_bus_err;
    logic [7:0]  d0_instret;
    logic [2:0]  d0_state;

    multicycle_controller #(.M_EXT(1'b1), .WAIT_TIMEOUT(4), .INSTRET_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
        .br_taken(br_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .muldiv_done(muldiv_done), .imem_req(imem_req), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we), .pcsrc(pcsrc),
        .regwrite(regwrite), .alusrc(alusrc), .memtoreg(memtoreg), .auipc(auipc),
        .lui(lui), .muldiv_sel(muldiv_sel), .alucontrol(alucontrol), .alu_sub(alu_sub),
        .muldiv_start(muldiv_start), .illegal(illegal), .bus_err(bus_err),
        .instret(instret), .state(state)
    );

    // Mul encoding with the M extension absent, memory always ready, done always high.
    multicycle_controller #(.M_EXT(1'b0), .WAIT_TIMEOUT(4), .INSTRET_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .op(7'b0110011), .funct3(3'b000), .funct7(7'b0000001),
        .br_taken(1'b0), .imem_ready(1'b1), .dmem_ready(1'b1),
        .muldiv_done(1'b1), .imem_req(d0_imem_req), .dmem_req(d0_dmem_req),
        .dmem_we(d0_dmem_we), .ir_we(d0_ir_we), .pc_we(d0_pc_we), .pcsrc(d0_pcsrc),
        .regwrite(d0_regwrite), .alusrc(d0_alusrc), .memtoreg(d0_memtoreg), .auipc(d0_auipc),
        .lui(d0_lui), .muldiv_sel(d0_muldiv_sel), .alucontrol(d0_alucontrol),
        .alu_sub(d0_alu_sub), .muldiv_start(d0_muldiv_start), .illegal(d0_illegal),
        .bus_err(d0_bus_err), .instret(d0_instret), .state(d0_state)
    );

    typedef struct {
        int          cycles;
        logic [1:0]  pcsrc;
        logic        regwrite, memtoreg, muldiv_sel;
        logic        chk_alu;
        logic [2:0]  aluc;
        logic        asub, alusrc, lui, auipc;
        int          dmem_cyc, dmem_we_cyc, starts;
        int          instret_before;
    } exp_t;

    exp_t scb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected behaviour of one instruction, from its class and the memory/mul latencies.
    function automatic exp_t model(input int cls, input logic [2:0] f3, input logic [6:0] f7,
                                   input logic bt, input int wi, input int wd, input int lat,
                                   input int ret);
        exp_t e;
        e = '{default: 0};
        e.chk_alu = 1'b1;
        e.instret_before = ret;
        e.cycles = 4 + wi;
        e.regwrite = 1'b1;
        case (cls)
            0: begin e.aluc = f3; e.asub = f7[5]; end
            1: begin e.aluc = f3; e.asub = (f3 == 3'd5) ? f7[5] : 1'b0; e.alusrc = 1'b1; end
            2: begin
                e.cycles = 5 + wi + wd; e.memtoreg = 1'b1; e.alusrc = 1'b1; e.dmem_cyc = wd + 1;
            end
            3: begin
                e.cycles = 4 + wi + wd; e.regwrite = 1'b0; e.alusrc = 1'b1;
                e.dmem_cyc = wd + 1; e.dmem_we_cyc = wd + 1;
            end
            4: begin e.cycles = 3 + wi; e.regwrite = 1'b0; e.asub = 1'b1; e.pcsrc = {1'b0, bt}; end
            5: e.pcsrc = 2'd1;
            6: e.pcsrc = 2'd2;
            7: e.lui = 1'b1;
            8: e.auipc = 1'b1;
            default: begin
                e.cycles = 3 + wi + lat; e.muldiv_sel = 1'b1; e.chk_alu = 1'b0; e.starts = 1;
            end
        endcase
        return e;
    endfunction

    int   issued = 0;
    bit   starve = 0;
    bit   illegal_mode = 0;
    bit   md_busy = 0;
    logic drv_prev_req = 1'b0;
    int   icnt = 0, dcnt = 0, mcnt = 0;
    int   cur_wi = 0, cur_wd = 0, cur_lat = 1;

    task automatic issue();
        int cls;
        if (illegal_mode) begin
            op = 7'b0000000; funct3 = 3'd0; funct7 = 7'd0; cur_wi = 0;
            return;
        end
        cls      = $urandom_range(0, 9);
        funct3   = 3'($urandom);
        funct7   = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000;
        br_taken = 1'($urandom);
        cur_wi   = $urandom_range(0, 3);
        cur_wd   = $urandom_range(0, 3);
        cur_lat  = $urandom_range(1, 6);
        case (cls)
            0: op = 7'b0110011;
            1: op = 7'b0010011;
            2: op = 7'b0000011;
            3: op = 7'b0100011;
            4: op = 7'b1100011;
            5: op = 7'b1101111;
            6: op = 7'b1100111;
            7: op = 7'b0110111;
            8: op = 7'b0010111;
            default: begin op = 7'b0110011; funct7 = 7'b0000001; end
        endcase
        scb.push_back(model(cls, funct3, funct7, br_taken, cur_wi, cur_wd, cur_lat, issued));
        issued++;
    endtask

    // One cycle of stimulus: issue on each new fetch, then answer the handshakes.
    task automatic step();
        @(negedge clk);
        if (imem_req && !drv_prev_req) begin
            icnt = 0;
            if (illegal_mode || issued < N_INSTR) issue();
            else starve = 1;
        end
        drv_prev_req = imem_req;
        if (imem_req) begin
            imem_ready = !starve && (icnt == cur_wi);
            icnt++;
        end else begin
            imem_ready = 1'b0;
        end
        if (dmem_req) begin
            dmem_ready = (dcnt == cur_wd);
            dcnt++;
        end else begin
            dmem_ready = 1'b0;
            dcnt = 0;
        end
        if (muldiv_start) begin
            md_busy = 1;
            mcnt = 0;
        end
        muldiv_done = md_busy && (mcnt == cur_lat - 1);
        if (muldiv_done) md_busy = 0;
        mcnt++;
    endtask

    initial begin
        exp_t e;
        int   cyc = 0, nd = 0, nwe = 0, ns = 0;
        logic mon_prev = 1'b0, exec_seen = 1'b0;
        logic [2:0] s_aluc = 3'd0;
        logic s_asub = 1'b0, s_alusrc = 1'b0, s_lui = 1'b0, s_auipc = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                mon_prev = 1'b0;
            end else begin
                if (imem_req && !mon_prev) begin
                    cyc = 1; nd = 0; nwe = 0; ns = 0; exec_seen = 1'b0;
                end else begin
                    cyc++;
                end
                mon_prev = imem_req;
                if (dmem_req)     nd++;
                if (dmem_we)      nwe++;
                if (muldiv_start) ns++;
                if (state == 3'd3 && !exec_seen) begin
                    exec_seen = 1'b1;
                    s_aluc = alucontrol; s_asub = alu_sub; s_alusrc = alusrc;
                    s_lui = lui; s_auipc = auipc;
                end
                if (pc_we) begin
                    if (scb.size() == 0) begin
                        check("retire_expected", 32'(pc_we), 32'd0);
                    end else begin
                        e = scb.pop_front();
                        check("cycles", cyc, e.cycles);
                        check("pcsrc", 32'(pcsrc), 32'(e.pcsrc));
                        check("regwrite", 32'(regwrite), 32'(e.regwrite));
                        check("memtoreg", 32'(memtoreg), 32'(e.memtoreg));
                        check("muldiv_sel", 32'(muldiv_sel), 32'(e.muldiv_sel));
                        check("alusrc", 32'(s_alusrc), 32'(e.alusrc));
                        check("lui", 32'(s_lui), 32'(e.lui));
                        check("auipc", 32'(s_auipc), 32'(e.auipc));
                        if (e.chk_alu) begin
                            check("alucontrol", 32'(s_aluc), 32'(e.aluc));
                            check("alu_sub", 32'(s_asub), 32'(e.asub));
                        end
                        check("dmem_req_cycles", nd, e.dmem_cyc);
                        check("dmem_we_cycles", nwe, e.dmem_we_cyc);
                        check("muldiv_start_pulses", ns, e.starts);
                        check("instret", instret, e.instret_before);
                        check("no_trap_flags", 32'({illegal, bus_err}), 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        int budget;
        int req_cnt;
        rst_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7 = 7'd0; br_taken = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0; muldiv_done = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_state", 32'(state), 32'd0);
        check("reset_instret", instret, 32'd0);
        check("reset_flags", 32'({illegal, bus_err}), 32'd0);
        check("reset_requests", 32'({imem_req, dmem_req, pc_we, regwrite}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_after_release", 32'(imem_req), 32'd0);
        step();
        #1;
        check("first_fetch_cycle", 32'(imem_req), 32'd1);

        budget = 0;
        while (!starve && budget < 20000) begin
            step();
            budget++;
        end
        check("random_phase_done", 32'(starve), 32'd1);

        // Fetch with imem_ready held low must trap after exactly four request cycles.
        req_cnt = 1;
        repeat (6) begin
            step();
            if (imem_req) req_cnt++;
        end
        check("timeout_req_cycles", req_cnt, 4);
        check("timeout_state", 32'(state), 32'd6);
        check("bus_err_set", 32'(bus_err), 32'd1);
        check("instret_total", instret, N_INSTR);
        check("scoreboard_drained", scb.size(), 0);
        repeat (3) step();
        check("bus_err_sticky", 32'(bus_err), 32'd1);
        check("trap_quiet", 32'({imem_req, dmem_req, pc_we, regwrite, ir_we}), 32'd0);

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_state", 32'(state), 32'd0);
        check("async_reset_bus_err", 32'(bus_err), 32'd0);
        check("async_reset_instret", instret, 32'd0);

        @(negedge clk);
        illegal_mode = 1;
        starve = 0;
        rst_n = 1'b1;
        repeat (5) step();
        check("illegal_state", 32'(state), 32'd6);
        check("illegal_set", 32'(illegal), 32'd1);
        check("illegal_no_bus_err", 32'(bus_err), 32'd0);
        check("illegal_no_retire", instret, 32'd0);
        check("m0_mul_state", 32'(d0_state), 32'd6);
        check("m0_mul_illegal", 32'(d0_illegal), 32'd1);
        check("m0_mul_no_retire", 32'(d0_instret), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
